// File: rtl/uart_rx_ctrl_pkg.sv
// Shared 8N1 UART definitions: receiver FSM encodings, frame shape and the
// baud divisor computation used by both the transmit and receive controllers.
package uart_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StStart    = 3'd1,
    StData     = 3'd2,
    StStop     = 3'd3,
    StWaitIdle = 3'd4
  } rx_state_e;

  localparam int unsigned DataBits = 8;
  localparam int unsigned StopBits = 1;

  function automatic int unsigned bit_tmr_max(input int unsigned clk_freq,
                                              input int unsigned baud);
    return clk_freq / baud - 1;
  endfunction

  function automatic int unsigned half_tmr_max(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / (2 * baud) - 1;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line; resets to the idle
// (high) level so a reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_ctrl.sv
// 8N1 UART receiver: start-bit validation, mid-bit sampling of 8 data bits
// LSB-first, stop-bit check, and a valid/ack output register with overrun flag.
module uart_rx_ctrl
  import uart_rx_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic       CLK,
  input  logic       rst,
  input  logic       UART_TXD_IN,
  input  logic       RX_ACK,
  output logic [7:0] DATA,
  output logic       RX_VALID,
  output logic       FRAME_ERR,
  output logic       OVERRUN
);

  localparam int unsigned BitTmrMax  = bit_tmr_max(CLK_FREQ, BAUD);
  localparam int unsigned HalfTmrMax = half_tmr_max(CLK_FREQ, BAUD);
  localparam int unsigned TmrW       = (BitTmrMax > 0) ? $clog2(BitTmrMax + 1) : 1;

  localparam logic [TmrW-1:0] BitLast  = TmrW'(BitTmrMax);
  localparam logic [TmrW-1:0] HalfLast = TmrW'(HalfTmrMax);
  localparam logic [2:0]      IdxLast  = 3'(DataBits - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk_i (CLK),
    .rst_i (rst),
    .d_i   (UART_TXD_IN),
    .q_o   (rx_s)
  );

  rx_state_e       state_q, state_d;
  logic [TmrW-1:0] timer_q, timer_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            accept;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    accept      = 1'b0;

    case (state_q)
      StIdle: begin
        if (!rx_s) begin
          timer_d = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (timer_q == HalfLast) begin
          if (!rx_s) begin
            timer_d = '0;
            idx_d   = '0;
            state_d = StData;
          end else begin
            state_d = StIdle;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StData: begin
        if (timer_q == BitLast) begin
          timer_d        = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + 3'd1;
          if (idx_q == IdxLast) state_d = StStop;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StStop: begin
        if (timer_q == BitLast) begin
          timer_d = '0;
          if (rx_s) begin
            accept  = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StWaitIdle;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StWaitIdle: begin
        // A held-low break stays here, so it reports a single framing error.
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // An ack on the accept edge frees the register for the new byte.
    if (accept) begin
      if (!valid_q || RX_ACK) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && RX_ACK) begin
      valid_d   = 1'b0;
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign DATA      = data_q;
  assign RX_VALID  = valid_q;
  assign FRAME_ERR = frame_err_q;
  assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl at 10 clocks per bit; frames are driven on
// falling clock edges and outputs are sampled away from the rising edge.
module tb_uart_rx_ctrl;

  localparam int unsigned ClkFreq = 1_000_000;
  localparam int unsigned Baud    = 100_000;
  localparam int unsigned BitClks = 10;

  logic       clk = 1'b0;
  logic       rst;
  logic       pin;
  logic       ack;
  logic [7:0] data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int checks   = 0;
  int errors   = 0;
  int fe_count = 0;

  uart_rx_ctrl #(
    .CLK_FREQ (ClkFreq),
    .BAUD     (Baud)
  ) dut (
    .CLK         (clk),
    .rst         (rst),
    .UART_TXD_IN (pin),
    .RX_ACK      (ack),
    .DATA        (data),
    .RX_VALID    (rx_valid),
    .FRAME_ERR   (frame_err),
    .OVERRUN     (overrun)
  );

  always #5 clk = ~clk;

  // Each high sample at a falling edge is one clock of FRAME_ERR.
  always @(negedge clk) if (frame_err === 1'b1) fe_count++;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete, got running want finished");
    $fatal(1);
  end

  // Called at a falling edge; returns at a falling edge with the stop level on the line.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    pin = 1'b0;
    repeat (BitClks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      pin = b[i];
      repeat (BitClks) @(negedge clk);
    end
    pin = stop_bit;
    repeat (BitClks) @(negedge clk);
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    pin = 1'b1;
    ack = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    checks++;
    if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single_byte();
    @(negedge clk);
    fork
      send_frame(8'h55, 1'b1);
      begin
        @(posedge clk);             // first edge that sees the falling pin
        repeat (96) @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_early: got %b want 0", rx_valid); end
        @(posedge clk);
        #1;
        checks++;
        if (rx_valid !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", rx_valid); end
        checks++;
        if (data !== 8'h55) begin errors++; $display("FAIL single_data: got %h want 55", data); end
      end
    join
    do_ack();
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL single_ack: got %b want 0", rx_valid); end
    do_ack();
    checks++;
    if (rx_valid !== 1'b0 || data !== 8'h55) begin
      errors++; $display("FAIL idle_ack: got valid=%b data=%h want 0/55", rx_valid, data);
    end
  endtask

  task automatic test_glitch();
    int fe_start;
    fe_start = fe_count;
    pin = 1'b0;
    repeat (3) @(negedge clk);
    pin = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
    checks++;
    if (fe_count != fe_start) begin
      errors++; $display("FAIL glitch_ferr: got %0d pulses want 0", fe_count - fe_start);
    end
    send_frame(8'h69, 1'b1);
    checks++;
    if (rx_valid !== 1'b1 || data !== 8'h69) begin
      errors++; $display("FAIL glitch_next: got valid=%b data=%h want 1/69", rx_valid, data);
    end
    do_ack();
  endtask

  task automatic test_frame_error();
    int fe_start;
    fe_start = fe_count;
    send_frame(8'hA3, 1'b0);
    repeat (30) @(negedge clk);
    pin = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (fe_count - fe_start != 1) begin
      errors++; $display("FAIL ferr_pulses: got %0d want 1", fe_count - fe_start);
    end
    checks++;
    if (rx_valid !== 1'b0) begin errors++; $display("FAIL ferr_valid: got %b want 0", rx_valid); end
    checks++;
    if (data !== 8'h69) begin errors++; $display("FAIL ferr_data: got %h want 69", data); end
    send_frame(8'h0A, 1'b1);
    checks++;
    if (rx_valid !== 1'b1 || data !== 8'h0A) begin
      errors++; $display("FAIL ferr_next: got valid=%b data=%h want 1/0a", rx_valid, data);
    end
    do_ack();
  endtask

  task automatic test_overrun();
    send_frame(8'h69, 1'b1);
    send_frame(8'h6C, 1'b1);
    checks++;
    if (data !== 8'h69) begin errors++; $display("FAIL ovr_data: got %h want 69", data); end
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid: got %b want 1", rx_valid); end
    checks++;
    if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
    do_ack();
    checks++;
    if (rx_valid !== 1'b0 || overrun !== 1'b0) begin
      errors++; $display("FAIL ovr_ack: got valid=%b ovr=%b want 0/0", rx_valid, overrun);
    end
  endtask

  task automatic test_back_to_back_ack();
    @(negedge clk);
    fork
      begin
        send_frame(8'h61, 1'b1);
        send_frame(8'h62, 1'b1);
      end
      begin
        repeat (98) @(negedge clk);
        checks++;
        if (rx_valid !== 1'b1 || data !== 8'h61) begin
          errors++; $display("FAIL b2b_first: got valid=%b data=%h want 1/61", rx_valid, data);
        end
        repeat (99) @(negedge clk);  // just before the stop sample of the second frame
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
      end
    join
    checks++;
    if (data !== 8'h62) begin errors++; $display("FAIL b2b_data: got %h want 62", data); end
    checks++;
    if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b want 1", rx_valid); end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_ovr: got %b want 0", overrun); end
  endtask

  task automatic test_reset_midframe();
    @(negedge clk);
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (55) @(negedge clk);  // middle of data bit 4
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (data !== 8'h00 || rx_valid !== 1'b0 || frame_err !== 1'b0 || overrun !== 1'b0) begin
          errors++;
          $display("FAIL midrst_outs: got data=%h valid=%b ferr=%b ovr=%b want 00/0/0/0",
                   data, rx_valid, frame_err, overrun);
        end
      end
    join
    repeat (5) @(negedge clk);
    send_frame(8'h30, 1'b1);
    checks++;
    if (rx_valid !== 1'b1 || data !== 8'h30) begin
      errors++; $display("FAIL midrst_next: got valid=%b data=%h want 1/30", rx_valid, data);
    end
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back_ack();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

UART receive controller: the receiving end of the 8N1 serial link whose transmit side is `UART_TX_CTRL`. It synchronises the board's serial input pin, detects and validates start bits, samples 8 data bits LSB-first at mid-bit, and checks the stop bit. Each good byte is held in an output register under a valid/ack handshake. It feeds the top-level command and instruction-load path (mode L, load instructions from UART), alongside the PS/2 keyboard input.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD`, default 9600: line rate in bits/s. Derived `BIT_TMR_MAX = CLK_FREQ/BAUD - 1`, `HALF_TMR_MAX = CLK_FREQ/(2*BAUD) - 1`.
- `CLK`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: reset. Synchronous and active-high.
- `UART_TXD_IN`, input, 1: asynchronous serial line. Idle level is 1.
- `DATA`, output, 8: last accepted byte. Reset value 0x00.
- `RX_VALID`, output, 1: `DATA` holds an unconsumed byte. Reset value 0.
- `RX_ACK`, input, 1: consumer accepts `DATA`. Only meaningful while `RX_VALID` is 1.
- `FRAME_ERR`, output, 1: one-cycle pulse when the stop bit is sampled as 0. Reset value 0.
- `OVERRUN`, output, 1: sticky flag; a byte was dropped because the previous one was still unconsumed. Reset value 0.

## Operation
- **Input synchroniser.** Two-flop synchroniser on `UART_TXD_IN`; both flops reset to 1. All decisions use the second flop (`rx_s`).
- **States:** IDLE, START, DATA, STOP, WAIT_IDLE.
- **IDLE:** when `rx_s` is 0, load the timer with 0 and go to START.
- **START:** count to `HALF_TMR_MAX`, then sample `rx_s`.
  - Sample is 0: clear the timer and bit index, go to DATA.
  - Sample is 1: treat as a glitch and return to IDLE. No outputs change.
- **DATA:** each time the timer reaches `BIT_TMR_MAX`, sample `rx_s` into shift register bit `idx`, then increment `idx` (3-bit). After `idx` = 7 is sampled, go to STOP.
- **STOP:** at `BIT_TMR_MAX`, sample `rx_s`.
  - Sample is 1 (byte accepted): go to IDLE.
  - Sample is 0 (framing error): pulse `FRAME_ERR`, discard the byte, go to WAIT_IDLE.
- **WAIT_IDLE:** stay until `rx_s` is 1, then go to IDLE. A held-low break produces exactly one `FRAME_ERR`.
- **Accept rules** (applied at the same edge as the stop sample):
  - `RX_VALID` = 0: `DATA` ← shift register, `RX_VALID` ← 1.
  - `RX_VALID` = 1 and `RX_ACK` = 1: same as above. The new byte replaces the old and `RX_VALID` stays 1.
  - `RX_VALID` = 1 and `RX_ACK` = 0: `DATA` keeps the old byte, the new byte is dropped, `OVERRUN` ← 1.
- **Ack rules:**
  - `RX_ACK` = 1 while `RX_VALID` = 1, with no simultaneous accept: `RX_VALID` ← 0 and `OVERRUN` ← 0 on the next edge.
  - `RX_ACK` while `RX_VALID` = 0 is ignored.
- **Reset:** `rst` at any point, including mid-frame, returns the FSM to IDLE, clears the timer, `idx` and shift register, restores all outputs to their reset values and sets the synchroniser flops to 1. Reception resumes at the next falling edge after `rst` is released.

## Timing
- Bit period is `BIT_TMR_MAX + 1` clocks. Samples fall at mid-bit ± 1 clock.
- Input latency: 2 clocks from the pin to `rx_s`.
- `RX_VALID` rises on the edge that samples the middle of the stop bit. That is 2 + (HALF_TMR_MAX+1) + 9·(BIT_TMR_MAX+1) clocks after the pin falls.
- Back-to-back frames with no idle gap between stop and the next start are received without loss. The FSM is in IDLE by mid-stop, half a bit before the next start edge.
- `FRAME_ERR` is exactly 1 clock wide.
- `DATA` is stable whenever `RX_VALID` is 1 and no accept occurs.

## Structure
- Shared header/package holds:
  - the FSM state encodings (3-bit constants IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4);
  - the 8N1 frame constants (8 data bits, 1 stop bit);
  - the divisor computation, so `UART_TX_CTRL` and this block use one baud definition.
- Sub-module `uart_rx_sync`: the two-flop synchroniser, reset to 1. Everything else stays in `uart_rx_ctrl`.

## Test plan
All scenarios use `CLK_FREQ`=1_000_000 and `BAUD`=100_000, giving 10 clocks/bit and `HALF_TMR_MAX`=4.
- **Single byte:** send 0x55 → `DATA`=0x55 and `RX_VALID`=1 exactly 2+5+90 clocks after the start edge. Pulse `RX_ACK` for 1 clock → `RX_VALID`=0 the next clock.
- **Glitch:** drive the line low for 3 clocks, then high → no `RX_VALID`, no `FRAME_ERR`, FSM back in IDLE. A following frame 0x69 is received correctly.
- **Framing error:** send 0xA3 with the stop bit at 0, hold the line low 30 clocks, then release → one `FRAME_ERR` pulse, `RX_VALID` stays 0, `DATA` unchanged. The next frame 0x0A is received correctly.
- **Overrun:** send 0x69 then 0x6C back-to-back without ack → `DATA`=0x69, `RX_VALID`=1, `OVERRUN`=1. Ack → both cleared.
- **Ack coincident with accept:** send 0x61 and 0x62 back-to-back, asserting `RX_ACK` on the stop-sample edge of 0x62 → `DATA`=0x62, `RX_VALID` stays 1, `OVERRUN`=0.
- **Reset mid-frame:** assert `rst` during data bit 4 of 0xFF → all outputs 0 next clock. A fresh 0x30 after release is received as 0x30.
